bram_arbiter: RTL

Two-master AXI4-Lite arbiter in front of the single-port BRAM AXI slave. Instruction fetch (port 0) and data load/store (port 1) share one slave port. One whole transaction is granted at a time, either a read (AR→R) or a write (AW+W→B). Grants rotate round-robin between the masters. Channels of the granted master are muxed combinationally to the slave; all other channels are held off.

---
 rtl/bram_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-master AXI4-Lite arbiter in front of a single-port BRAM slave.
// It grants one whole transaction at a time (AR->R or AW+W->B) and rotates
// round-robin between instruction fetch (port 0) and data access (port 1).
// The channels of the granted master are muxed combinationally to the slave.
// All other channels are held off.
module bram_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    // master 0 (instruction fetch)
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [2:0]            s0_axi_arprot,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [31:0]           s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
    input  logic [2:0]            s0_axi_awprot,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [31:0]           s0_axi_wdata,
    input  logic [3:0]            s0_axi_wstrb,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic [1:0]            s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    // master 1 (data load/store)
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [2:0]            s1_axi_arprot,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [31:0]           s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
    input  logic [2:0]            s1_axi_awprot,
    input  logic                  s1_axi_awvalid,
    output logic                  s1_axi_awready,
    input  logic [31:0]           s1_axi_wdata,
    input  logic [3:0]            s1_axi_wstrb,
    input  logic                  s1_axi_wvalid,
    output logic                  s1_axi_wready,
    output logic [1:0]            s1_axi_bresp,
    output logic                  s1_axi_bvalid,
    input  logic                  s1_axi_bready,
    // slave port (BRAM)
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // debug
    output logic                  grant,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       rdreq0, rdreq1, wrreq0, wrreq1, req0, req1;
    logic       sel;
    logic       rd_act, wr_act;

    assign rdreq0 = s0_axi_arvalid;
    assign rdreq1 = s1_axi_arvalid;
    assign wrreq0 = s0_axi_awvalid | s0_axi_wvalid;
    assign wrreq1 = s1_axi_awvalid | s1_axi_wvalid;
    assign req0   = rdreq0 | wrreq0;
    assign req1   = rdreq1 | wrreq1;

    assign rd_act = (state_q == ST_READ);
    assign wr_act = (state_q == ST_WRITE);

    // Next state: arbitrate in IDLE, otherwise wait for the completion handshake.
    always_comb begin
        // NOTE: every variable gets a default first so no branch leaves it unassigned (no latch).
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        sel     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    // Contention goes to the master that was not served last.
                    sel     = (req0 & req1) ? ~last_q : req1;
                    grant_d = sel;
                    last_d  = sel;
                    // Read takes priority over write within one master.
                    state_d = (sel ? rdreq1 : rdreq0) ? ST_READ : ST_WRITE;
                end
            end
            ST_READ:  if (m_axi_rvalid & m_axi_rready) state_d = ST_IDLE;
            ST_WRITE: if (m_axi_bvalid & m_axi_bready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Arbiter state registers; reset leaves master 0 first in line.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses nonblocking assignments so all flops update together.
        if (!rstn) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Slave-side request channels follow the granted master; valids are gated by state.
    assign m_axi_araddr  = grant_q ? s1_axi_araddr : s0_axi_araddr;
    assign m_axi_arprot  = grant_q ? s1_axi_arprot : s0_axi_arprot;
    assign m_axi_arvalid = rd_act & (grant_q ? s1_axi_arvalid : s0_axi_arvalid);
    assign m_axi_rready  = rd_act & (grant_q ? s1_axi_rready : s0_axi_rready);
    assign m_axi_awaddr  = grant_q ? s1_axi_awaddr : s0_axi_awaddr;
    assign m_axi_awprot  = grant_q ? s1_axi_awprot : s0_axi_awprot;
    assign m_axi_awvalid = wr_act & (grant_q ? s1_axi_awvalid : s0_axi_awvalid);
    assign m_axi_wdata   = grant_q ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb   = grant_q ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wvalid  = wr_act & (grant_q ? s1_axi_wvalid : s0_axi_wvalid);
    assign m_axi_bready  = wr_act & (grant_q ? s1_axi_bready : s0_axi_bready);

    // Handshake returns reach only the granted master.
    assign s0_axi_arready = rd_act & ~grant_q & m_axi_arready;
    assign s1_axi_arready = rd_act &  grant_q & m_axi_arready;
    assign s0_axi_rvalid  = rd_act & ~grant_q & m_axi_rvalid;
    assign s1_axi_rvalid  = rd_act &  grant_q & m_axi_rvalid;
    assign s0_axi_awready = wr_act & ~grant_q & m_axi_awready;
    assign s1_axi_awready = wr_act &  grant_q & m_axi_awready;
    assign s0_axi_wready  = wr_act & ~grant_q & m_axi_wready;
    assign s1_axi_wready  = wr_act &  grant_q & m_axi_wready;
    assign s0_axi_bvalid  = wr_act & ~grant_q & m_axi_bvalid;
    assign s1_axi_bvalid  = wr_act &  grant_q & m_axi_bvalid;

    // Response payloads are broadcast; only the valids above are gated.
    assign s0_axi_rdata = m_axi_rdata;
    assign s1_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s1_axi_rresp = m_axi_rresp;
    assign s0_axi_bresp = m_axi_bresp;
    assign s1_axi_bresp = m_axi_bresp;

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
